manual_step_gen: RTL and testbench

- Front-end conditioner for the board push-button and clock-mode switches.
- Turns a bouncing button into exactly one clean, fixed-width manual_clk pulse per press.
- Debounces the two clock-select switches and counts accepted steps.
- Runs on the board oscillator. Outputs feed the clock-selection stage: manual_clk into its manual input, sw_stable into its mode select.

---
 rtl/manual_step_gen.sv | 164 ++++++++++++++++
 tb/tb_manual_step_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/manual_step_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | manual_step_gen: debounced single-step clock pulse and switch conditioner |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module manual_step_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int PULSE_CYCLES    = 8,
  parameter int SW_W            = 2
) (
  input  logic            clk_in1,
  input  logic            resetn,
  input  logic            btn_raw,
  input  logic [SW_W-1:0] sw_raw,
  output logic            manual_clk,
  output logic [SW_W-1:0] sw_stable,
  output logic [15:0]     step_count,
  output logic            busy
);

  localparam logic [CNT_W-1:0] C_DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] S_PULSE        = 3'd2;
  localparam logic [2:0] S_HELD         = 3'd3;
  localparam logic [2:0] S_RELEASE_WAIT = 3'd4;

  logic            btn_meta_q, btn_s_q;
  logic [SW_W-1:0] sw_meta_q, sw_s_q, sw_prev_q;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             manual_clk_q, manual_clk_d;
  logic             busy_q, busy_d;
  logic [15:0]      step_count_q, step_count_d;

  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [SW_W-1:0]  sw_stable_q, sw_stable_d;

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
      sw_prev_q  <= '0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_s_q    <= btn_meta_q;
      sw_meta_q  <= sw_raw;
      sw_s_q     <= sw_meta_q;
      sw_prev_q  <= sw_s_q;
    end
  end

  // bcnt is shared: debounce count in the wait states, pulse width in PULSE.
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    manual_clk_d = manual_clk_q;
    step_count_d = step_count_q;
    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        if (btn_s_q) state_d = S_PRESS_WAIT;
      end
      S_PRESS_WAIT: begin
        if (!btn_s_q) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
        end else if (bcnt_q == C_DEB_LAST) begin
          state_d      = S_PULSE;
          bcnt_d       = '0;
          manual_clk_d = 1'b1;
          step_count_d = step_count_q + 16'd1;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_PULSE: begin
        if (bcnt_q == C_PULSE_LAST) begin
          state_d      = S_HELD;
          bcnt_d       = '0;
          manual_clk_d = 1'b0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_HELD: begin
        bcnt_d = '0;
        if (!btn_s_q) state_d = S_RELEASE_WAIT;
      end
      S_RELEASE_WAIT: begin
        if (btn_s_q) begin
          state_d = S_HELD;
          bcnt_d  = '0;
        end else if (bcnt_q == C_DEB_LAST) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: begin
        state_d      = S_IDLE;
        bcnt_d       = '0;
        manual_clk_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      bcnt_q       <= '0;
      manual_clk_q <= 1'b0;
      busy_q       <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      manual_clk_q <= manual_clk_d;
      busy_q       <= busy_d;
      step_count_q <= step_count_d;
    end
  end

  // Whole vector is latched in one go, so a multi-bit change never appears piecemeal.
  always_comb begin
    sw_stable_d = sw_stable_q;
    scnt_d      = scnt_q;
    if (sw_s_q == sw_stable_q) begin
      scnt_d = '0;
    end else if (sw_s_q != sw_prev_q) begin
      scnt_d = '0;
    end else if (scnt_q == C_DEB_LAST) begin
      sw_stable_d = sw_s_q;
      scnt_d      = '0;
    end else begin
      scnt_d = scnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      scnt_q      <= '0;
      sw_stable_q <= '0;
    end else begin
      scnt_q      <= scnt_d;
      sw_stable_q <= sw_stable_d;
    end
  end

  assign manual_clk = manual_clk_q;
  assign busy       = busy_q;
  assign step_count = step_count_q;
  assign sw_stable  = sw_stable_q;

endmodule
`default_nettype wire

// File: tb/tb_manual_step_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_manual_step_gen: directed bench for manual_step_gen (DEB=8, PULSE=4)  |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_manual_step_gen;

  logic        clk;
  logic        resetn;
  logic        btn_raw;
  logic [1:0]  sw_raw;
  logic        manual_clk;
  logic [1:0]  sw_stable;
  logic [15:0] step_count;
  logic        busy;

  int errors = 0;
  int checks = 0;

  manual_step_gen #(
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4),
    .PULSE_CYCLES   (4),
    .SW_W           (2)
  ) dut (
    .clk_in1   (clk),
    .resetn    (resetn),
    .btn_raw   (btn_raw),
    .sw_raw    (sw_raw),
    .manual_clk(manual_clk),
    .sw_stable (sw_stable),
    .step_count(step_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    btn_raw = 1'b0;
    sw_raw  = 2'b00;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
  endtask

  // Edge k=1 is the edge that first samples the new btn_raw level.
  initial begin
    resetn  = 1'b0;
    btn_raw = 1'b0;
    sw_raw  = 2'b00;

    // Test 1: reset state, clean press held, clean release
    do_reset();
    chk("t1 reset manual_clk", {31'd0, manual_clk}, 32'd0);
    chk("t1 reset busy", {31'd0, busy}, 32'd0);
    chk("t1 reset step_count", {16'd0, step_count}, 32'd0);
    chk("t1 reset sw_stable", {30'd0, sw_stable}, 32'd0);
    btn_raw = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("t1 press manual_clk k=%0d", k), {31'd0, manual_clk}, (k >= 11 && k <= 14) ? 32'd1 : 32'd0);
      chk($sformatf("t1 press busy k=%0d", k), {31'd0, busy}, (k >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("t1 press step_count k=%0d", k), {16'd0, step_count}, (k >= 11) ? 32'd1 : 32'd0);
    end
    btn_raw = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk($sformatf("t1 release busy k=%0d", k), {31'd0, busy}, (k < 11) ? 32'd1 : 32'd0);
      chk($sformatf("t1 release manual_clk k=%0d", k), {31'd0, manual_clk}, 32'd0);
    end

    // Test 2: press bounce (3 high / 3 low) then steady high
    do_reset();
    for (int c = 0; c < 18; c++) begin
      btn_raw = ((c / 3) % 2 == 0);
      tick();
      chk($sformatf("t2 bounce manual_clk c=%0d", c), {31'd0, manual_clk}, 32'd0);
      chk($sformatf("t2 bounce step_count c=%0d", c), {16'd0, step_count}, 32'd0);
    end
    btn_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("t2 steady manual_clk k=%0d", k), {31'd0, manual_clk}, (k >= 11 && k <= 14) ? 32'd1 : 32'd0);
      chk($sformatf("t2 steady step_count k=%0d", k), {16'd0, step_count}, (k >= 11) ? 32'd1 : 32'd0);
    end

    // Test 3: release bounce low 3, high 2, then low steady (final fall sampled at k=6)
    for (int k = 1; k <= 24; k++) begin
      btn_raw = (k == 4 || k == 5);
      tick();
      chk($sformatf("t3 manual_clk k=%0d", k), {31'd0, manual_clk}, 32'd0);
      chk($sformatf("t3 step_count k=%0d", k), {16'd0, step_count}, 32'd1);
      chk($sformatf("t3 busy k=%0d", k), {31'd0, busy}, (k < 16) ? 32'd1 : 32'd0);
    end

    // Test 4: switch 00 -> 11 glitch for 5 cycles -> 10 steady
    do_reset();
    sw_raw = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("t4 glitch sw_stable k=%0d", k), {30'd0, sw_stable}, 32'd0);
    end
    sw_raw = 2'b10;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk($sformatf("t4 settle sw_stable k=%0d", k), {30'd0, sw_stable}, (k >= 11) ? 32'd2 : 32'd0);
      chk($sformatf("t4 settle busy k=%0d", k), {31'd0, busy}, 32'd0);
    end

    // Test 5: asynchronous reset in the 2nd pulse cycle, button still held
    do_reset();
    btn_raw = 1'b1;
    for (int k = 1; k <= 12; k++) tick();
    chk("t5 pre-reset manual_clk", {31'd0, manual_clk}, 32'd1);
    chk("t5 pre-reset step_count", {16'd0, step_count}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("t5 async manual_clk", {31'd0, manual_clk}, 32'd0);
    chk("t5 async busy", {31'd0, busy}, 32'd0);
    chk("t5 async step_count", {16'd0, step_count}, 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk($sformatf("t5 repress manual_clk k=%0d", k), {31'd0, manual_clk}, (k >= 11 && k <= 14) ? 32'd1 : 32'd0);
      chk($sformatf("t5 repress step_count k=%0d", k), {16'd0, step_count}, (k >= 11) ? 32'd1 : 32'd0);
    end
    btn_raw = 1'b0;

    // Test 6: step_count wrap from 16'hFFFF
    do_reset();
    force dut.step_count_q = 16'hFFFF;
    #1;
    release dut.step_count_q;
    chk("t6 preload step_count", {16'd0, step_count}, 32'h0000FFFF);
    btn_raw = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("t6 step_count k=%0d", k), {16'd0, step_count}, (k >= 11) ? 32'h0 : 32'h0000FFFF);
      chk($sformatf("t6 manual_clk k=%0d", k), {31'd0, manual_clk}, (k >= 11 && k <= 14) ? 32'd1 : 32'd0);
    end
    btn_raw = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
